avalon_s_mem_device: RTL and testbench



---
 rtl/avalon_s_mem_device.sv | 131 +++++++++++++
 tb/tb_avalon_s_mem_device.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_s_mem_device.sv
// Avalon-MM waitrequest-based memory device: word-addressed register array with byte enables and WAIT wait states.
// Optional AVN_DEVICE_ERR_EN adds a sticky avn_err flag for read+write collisions and out-of-range addresses.
module avalon_s_mem_device #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WAIT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            avn_read,
    input  logic            avn_write,
    input  logic [AW-1:0]   avn_address,
    input  logic [DW/8-1:0] avn_byte_enable,
    input  logic [DW-1:0]   avn_writedata,
    output logic [DW-1:0]   avn_readdata,
    output logic            avn_waitrequest
`ifdef AVN_DEVICE_ERR_EN
    ,
    output logic            avn_err
`endif
);

    localparam int unsigned BW        = DW / 8;
    localparam int unsigned OFFW      = $clog2(BW);
    localparam int unsigned IDXW      = $clog2(DEPTH);
    localparam int unsigned CW        = 4;
    localparam bit          ZERO_WAIT = (WAIT == 0);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [DW-1:0]      mem [DEPTH];

    logic               req_c;
    logic               done_c;
    logic               upper_c;
    logic               wr_en_c;
    logic               rd_en_c;
    logic [IDXW-1:0]    idx_c;
    logic               unused_addr;

    assign req_c       = avn_read | avn_write;
    assign idx_c       = avn_address[OFFW +: IDXW];
    assign unused_addr = ^avn_address;

`ifdef AVN_DEVICE_ERR_EN
    assign upper_c = (avn_address >> (OFFW + IDXW)) != '0;
`else
    assign upper_c = 1'b0;
`endif

    // Handshake decode: stall during reset, and while the wait-state count is short of WAIT.
    always_comb begin
        done_c          = 1'b0;
        avn_waitrequest = 1'b1;
        if (!rst) begin
            if (!req_c) begin
                avn_waitrequest = 1'b0;
            end else if (state == ST_IDLE) begin
                if (ZERO_WAIT) begin
                    done_c          = 1'b1;
                    avn_waitrequest = 1'b0;
                end
            end else if (cnt == CW'(WAIT)) begin
                done_c          = 1'b1;
                avn_waitrequest = 1'b0;
            end
        end
    end

    // Write wins over read when both are asserted; out-of-range accesses are suppressed.
    assign wr_en_c      = done_c & avn_write & ~upper_c;
    assign rd_en_c      = done_c & avn_read & ~avn_write & ~upper_c;
    assign avn_readdata = rd_en_c ? mem[idx_c] : '0;

    // Wait-state sequencer; a dropped request aborts the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_c && !ZERO_WAIT) begin
                        state <= ST_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (!req_c || cnt == CW'(WAIT)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en_c) begin
            for (int i = 0; i < int'(BW); i++) begin
                if (avn_byte_enable[i]) begin
                    mem[idx_c][8*i +: 8] <= avn_writedata[8*i +: 8];
                end
            end
        end
    end

`ifdef AVN_DEVICE_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            avn_err <= 1'b0;
        end else if (req_c && ((avn_read && avn_write) || upper_c)) begin
            avn_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_s_mem_device.sv
// Scoreboard bench for avalon_s_mem_device with three instances (WAIT = 0, 1, 3).
module tb_avalon_s_mem_device;

    logic        clk;
    logic        rst;
    logic        rd      [3];
    logic        wr      [3];
    logic [31:0] addr    [3];
    logic [3:0]  be      [3];
    logic [31:0] wdata   [3];
    logic [31:0] rdata   [3];
    logic        wreq    [3];
`ifdef AVN_DEVICE_ERR_EN
    logic        err     [3];
`endif

    logic [31:0] model [3][256];
    logic [31:0] exp_q [$];
    int          n_tests;
    int          n_fail;

    avalon_s_mem_device #(.DW(32), .AW(32), .DEPTH(256), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst), .avn_read(rd[0]), .avn_write(wr[0]), .avn_address(addr[0]),
        .avn_byte_enable(be[0]), .avn_writedata(wdata[0]), .avn_readdata(rdata[0]),
        .avn_waitrequest(wreq[0])
`ifdef AVN_DEVICE_ERR_EN
        , .avn_err(err[0])
`endif
    );

    avalon_s_mem_device #(.DW(32), .AW(32), .DEPTH(256), .WAIT(1)) u_w1 (
        .clk(clk), .rst(rst), .avn_read(rd[1]), .avn_write(wr[1]), .avn_address(addr[1]),
        .avn_byte_enable(be[1]), .avn_writedata(wdata[1]), .avn_readdata(rdata[1]),
        .avn_waitrequest(wreq[1])
`ifdef AVN_DEVICE_ERR_EN
        , .avn_err(err[1])
`endif
    );

    avalon_s_mem_device #(.DW(32), .AW(32), .DEPTH(256), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst), .avn_read(rd[2]), .avn_write(wr[2]), .avn_address(addr[2]),
        .avn_byte_enable(be[2]), .avn_writedata(wdata[2]), .avn_readdata(rdata[2]),
        .avn_waitrequest(wreq[2])
`ifdef AVN_DEVICE_ERR_EN
        , .avn_err(err[2])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input int s);
        return (s == 0) ? 0 : ((s == 1) ? 1 : 3);
    endfunction

    function automatic bit in_range(input logic [31:0] a);
`ifdef AVN_DEVICE_ERR_EN
        return a[31:10] == 22'd0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 256; k++)
                model[s][k] = 32'd0;
    endtask

    task automatic all_idle();
        for (int s = 0; s < 3; s++) begin
            rd[s] = 1'b0;
            wr[s] = 1'b0;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                check($sformatf("rst_wreq%0d", s), 32'(wreq[s]), 32'd1);
                check($sformatf("rst_rdata%0d", s), rdata[s], 32'd0);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        all_idle();
        clear_model();
    endtask

    // One transfer; leaves the request asserted so the caller can chain back-to-back.
    task automatic xfer(input int s, input bit do_rd, input bit do_wr, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, input string tag);
        int          n;
        logic [7:0]  ix;
        ix       = a[9:2];
        rd[s]    = do_rd;
        wr[s]    = do_wr;
        addr[s]  = a;
        be[s]    = b;
        wdata[s] = d;
        if (do_rd)
            exp_q.push_back((!do_wr && in_range(a)) ? model[s][ix] : 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wreq[s] && n < 64);
        check({tag, "_lat"}, 32'(n), 32'(wait_of(s) + 1));
        if (do_rd && exp_q.size() > 0)
            check({tag, "_rd"}, rdata[s], exp_q.pop_front());
        if (do_wr && in_range(a))
            for (int i = 0; i < 4; i++)
                if (b[i]) model[s][ix][8*i +: 8] = d[8*i +: 8];
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle(input string tag);
        all_idle();
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("%s_wreq%0d", tag, s), 32'(wreq[s]), 32'd0);
            check($sformatf("%s_rdata%0d", tag, s), rdata[s], 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        for (int s = 0; s < 3; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = 32'd0; be[s] = 4'd0; wdata[s] = 32'd0;
        end
        clear_model();
        rd[0]   = 1'b1;
        addr[0] = 32'h10;
        do_reset(2);
        idle_cycle("post_rst");
        xfer(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'd0, "rd_after_rst");

        xfer(1, 1'b0, 1'b1, 32'h04, 4'hF, 32'hDEADBEEF, "w1_wr");
        idle_cycle("i1");
        xfer(1, 1'b1, 1'b0, 32'h04, 4'hF, 32'd0, "w1_rd");
        idle_cycle("i2");

        xfer(1, 1'b0, 1'b1, 32'h08, 4'hF, 32'h11223344, "be_init");
        xfer(1, 1'b0, 1'b1, 32'h08, 4'h5, 32'hAABBCCDD, "be_wr");
        xfer(1, 1'b1, 1'b0, 32'h08, 4'h0, 32'd0, "be_rd");
        idle_cycle("i3");

        for (int i = 0; i < 4; i++)
            xfer(0, 1'b0, 1'b1, 32'(i * 4), 4'hF, 32'hA5000000 + 32'(i * 17), $sformatf("b2b_wr%0d", i));
        for (int i = 0; i < 4; i++)
            xfer(0, 1'b1, 1'b0, 32'(i * 4), 4'hF, 32'd0, $sformatf("b2b_rd%0d", i));
        idle_cycle("i4");

        xfer(1, 1'b1, 1'b1, 32'h30, 4'hF, 32'h12345678, "rw_both");
        idle_cycle("i5");
        xfer(1, 1'b1, 1'b0, 32'h30, 4'hF, 32'd0, "rw_readback");
        idle_cycle("i6");

`ifdef AVN_DEVICE_ERR_EN
        check("err_rw", 32'(err[1]), 32'd1);
        check("err_clean0", 32'(err[0]), 32'd0);
        do_reset(1);
        check("err_rst", 32'(err[0]), 32'd0);
        xfer(0, 1'b0, 1'b1, 32'h400, 4'hF, 32'hCAFEF00D, "oor_wr");
        idle_cycle("i7");
        check("err_oor", 32'(err[0]), 32'd1);
        xfer(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'd0, "oor_mem0");
        xfer(0, 1'b1, 1'b0, 32'h400, 4'hF, 32'd0, "oor_rd");
        idle_cycle("i8");
        check("err_sticky", 32'(err[0]), 32'd1);
`else
        xfer(1, 1'b0, 1'b1, 32'h414, 4'hF, 32'h0BADF00D, "alias_wr");
        idle_cycle("i7");
        xfer(1, 1'b1, 1'b0, 32'h14, 4'hF, 32'd0, "alias_rd");
        idle_cycle("i8");
`endif

        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra;
            ra = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 1) == 1)
                xfer(1, 1'b0, 1'b1, ra, 4'($urandom_range(0, 15)), $urandom, $sformatf("rnd_wr%0d", i));
            else
                xfer(1, 1'b1, 1'b0, ra, 4'hF, 32'd0, $sformatf("rnd_rd%0d", i));
        end
        idle_cycle("i9");

        // Abort: drop a WAIT=3 write after two stalled cycles.
        wr[2] = 1'b1; addr[2] = 32'h20; be[2] = 4'hF; wdata[2] = 32'h55;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("abort_wreq%0d", c), 32'(wreq[2]), 32'd1);
            @(posedge clk); #1;
        end
        idle_cycle("i10");
        xfer(2, 1'b1, 1'b0, 32'h20, 4'hF, 32'd0, "abort_rd");
        idle_cycle("i11");

        // Reset in the middle of a stalled write.
        wr[2] = 1'b1; addr[2] = 32'h20; be[2] = 4'hF; wdata[2] = 32'h55;
        @(negedge clk);
        check("rabort_wreq", 32'(wreq[2]), 32'd1);
        @(posedge clk); #1;
        do_reset(1);
        xfer(2, 1'b1, 1'b0, 32'h20, 4'hF, 32'd0, "rabort_rd");
        idle_cycle("i12");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
